// File: rtl/vga_layer_compositor.sv
// Two-stage pixel compositor: N rectangle channels, text overlay, floor, background,
// plus per-frame collision reporting against channel 0 and a damage-flash blink.
module vga_layer_compositor #(
  parameter int          N_OBJ        = 4,
  parameter logic [9:0]  FLOOR_Y      = 10'd315,
  parameter logic [23:0] BG_RGB       = 24'hFFFFFF,
  parameter logic [23:0] FLOOR_RGB    = 24'h808080,
  parameter logic [7:0]  FLASH_FRAMES = 8'd60,
  parameter int          BLINK_LOG2   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                active_pixels,
  input  logic                frame_start,
  input  logic [10*N_OBJ-1:0] obj_x,
  input  logic [10*N_OBJ-1:0] obj_y,
  input  logic [10*N_OBJ-1:0] obj_w,
  input  logic [10*N_OBJ-1:0] obj_h,
  input  logic [24*N_OBJ-1:0] obj_rgb,
  input  logic [N_OBJ-1:0]    obj_en,
  input  logic                overlay_on,
  input  logic [23:0]         overlay_rgb,
  input  logic                hit_pulse,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                pix_valid,
  output logic [N_OBJ-1:0]    collide_mask,
  output logic                flashing
);

  logic [N_OBJ-1:0] hit_d, hit_q;
  logic             active_d, active_q;
  logic             ovl_on_d, ovl_on_q;
  logic [23:0]      ovl_rgb_d, ovl_rgb_q;
  logic             floor_d, floor_q;
  logic [23:0]      rgb0_d, rgb0_q;
  logic [23:0]      rgb_lo_d, rgb_lo_q;
  logic             any_lo_d, any_lo_q;

  logic [23:0]      rgb_d, rgb_q;
  logic             pix_valid_d, pix_valid_q;
  logic [N_OBJ-1:0] acc_d, acc_q;
  logic [N_OBJ-1:0] collide_d, collide_q;
  logic [7:0]       flash_cnt_d, flash_cnt_q;
  logic             flashing_d, flashing_q;

  logic [N_OBJ-1:0] coll;
  logic             vis0;

  // 11-bit bounds so right/bottom edges past 1023 never wrap to 0
  for (genvar k = 0; k < N_OBJ; k++) begin : g_hit
    logic [10:0] x0, x1, y0, y1;
    logic [10:0] px, py;
    assign px = {1'b0, x};
    assign py = {1'b0, y};
    assign x0 = {1'b0, obj_x[10*k +: 10]};
    assign y0 = {1'b0, obj_y[10*k +: 10]};
    assign x1 = x0 + {1'b0, obj_w[10*k +: 10]};
    assign y1 = y0 + {1'b0, obj_h[10*k +: 10]};
    assign hit_d[k] = obj_en[k] &&
                      (px >= x0) && (px < x1) &&
                      (py >= y0) && (py < y1);
  end

  always_comb begin
    rgb_lo_d = '0;
    any_lo_d = 1'b0;
    for (int k = N_OBJ - 1; k >= 1; k--) begin
      if (hit_d[k]) begin
        rgb_lo_d = obj_rgb[24*k +: 24];
        any_lo_d = 1'b1;
      end
    end
  end

  always_comb begin
    active_d  = active_pixels;
    ovl_on_d  = overlay_on;
    ovl_rgb_d = overlay_rgb;
    floor_d   = (y > FLOOR_Y);
    rgb0_d    = obj_rgb[23:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q     <= '0;
      active_q  <= 1'b0;
      ovl_on_q  <= 1'b0;
      ovl_rgb_q <= '0;
      floor_q   <= 1'b0;
      rgb0_q    <= '0;
      rgb_lo_q  <= '0;
      any_lo_q  <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      active_q  <= active_d;
      ovl_on_q  <= ovl_on_d;
      ovl_rgb_q <= ovl_rgb_d;
      floor_q   <= floor_d;
      rgb0_q    <= rgb0_d;
      rgb_lo_q  <= rgb_lo_d;
      any_lo_q  <= any_lo_d;
    end
  end

  // Player blinks off while the selected flash-counter bit is set
  assign vis0 = hit_q[0] && !(flashing_q && flash_cnt_q[BLINK_LOG2]);

  always_comb begin
    pix_valid_d = active_q;
    if (!active_q) begin
      rgb_d = '0;
    end else if (ovl_on_q) begin
      rgb_d = ovl_rgb_q;
    end else if (vis0) begin
      rgb_d = rgb0_q;
    end else if (any_lo_q) begin
      rgb_d = rgb_lo_q;
    end else if (floor_q) begin
      rgb_d = FLOOR_RGB;
    end else begin
      rgb_d = BG_RGB;
    end
  end

  // Raw hit is used so a blinked-off player still collides
  always_comb begin
    coll    = '0;
    if (active_q && hit_q[0]) begin
      coll    = hit_q;
      coll[0] = 1'b0;
    end
    collide_d = collide_q;
    acc_d     = acc_q | coll;
    if (frame_start) begin
      collide_d = acc_q;
      acc_d     = coll;
    end
  end

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (hit_pulse) begin
      flash_cnt_d = FLASH_FRAMES;
    end else if (frame_start && (flash_cnt_q != 8'd0)) begin
      flash_cnt_d = flash_cnt_q - 8'd1;
    end
    flashing_d = (flash_cnt_d != 8'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      acc_q       <= '0;
      collide_q   <= '0;
      flash_cnt_q <= '0;
      flashing_q  <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
      acc_q       <= acc_d;
      collide_q   <= collide_d;
      flash_cnt_q <= flash_cnt_d;
      flashing_q  <= flashing_d;
    end
  end

  assign VGA_R        = rgb_q[23:16];
  assign VGA_G        = rgb_q[15:8];
  assign VGA_B        = rgb_q[7:0];
  assign pix_valid    = pix_valid_q;
  assign collide_mask = collide_q;
  assign flashing     = flashing_q;

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Registered, parametrised pixel compositor for the playing screen. It replaces fixed player/obstacle/bank drawing with N generic rectangle channels, a text overlay, a floor band and a background. It adds a 2-stage pixel pipeline, per-frame collision reporting against channel 0 (the player), and a frame-counted damage-flash blink. It sits between the VGA timing generator and the DAC pins; game logic drives the object geometry.

## Interface
Parameters:
- N_OBJ, 4: number of rectangle channels; channel 0 is the player.
- FLOOR_Y, 10'd315: rows with y > FLOOR_Y are floor.
- BG_RGB, 24'hFFFFFF: background colour, {R,G,B}.
- FLOOR_RGB, 24'h808080: floor colour.
- FLASH_FRAMES, 8'd60: damage-flash length in frames (1..255).
- BLINK_LOG2, 2: channel 0 is hidden when flash_cnt[BLINK_LOG2] is 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- x, y  in  10 each  current pixel coordinate.
- active_pixels  in  1  visible-region flag, aligned with x/y.
- frame_start  in  1  one-cycle pulse, issued once per frame in vertical blank.
- obj_x, obj_y, obj_w, obj_h  in  10*N_OBJ each  flattened geometry; channel k occupies bits [10k+9:10k].
- obj_rgb  in  24*N_OBJ  per-channel colour.
- obj_en  in  N_OBJ  per-channel enable.
- overlay_on  in  1  text pixel, aligned with x/y.
- overlay_rgb  in  24  text colour.
- hit_pulse  in  1  one-cycle damage event.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.
- pix_valid  out  1  active_pixels delayed 2 cycles.
- collide_mask  out  N_OBJ  per-frame overlap result; bit k set means channel 0 overlapped channel k. Bit 0 is always 0.
- flashing  out  1  high while flash_cnt != 0.

## Operation
- **Stage 1 (register):** per-channel hit. hit[k] is high when all of the following hold: obj_en[k]; x >= obj_x; x < obj_x+obj_w; y >= obj_y; y < obj_y+obj_h.
  - Sums are computed at 11 bits, so there is no wrap. A width or height of 0 never hits.
  - Stage 1 also registers active, overlay_on, overlay_rgb, the floor flag (y > FLOOR_Y) and the selected object colour.
- **Visibility:** vis[k] = hit[k], except vis[0] = hit[0] && !(flashing && flash_cnt[BLINK_LOG2]).
- **Stage 2 (register):** colour select, highest priority first:
  - !active → 0.
  - overlay_on → overlay_rgb.
  - Lowest-index k with vis[k] → obj_rgb[k].
  - Floor flag → FLOOR_RGB.
  - Otherwise → BG_RGB.
- **Collision accumulator (acc, N_OBJ bits):**
  - On an active pixel where hit[0] && hit[k] for k >= 1, set acc[k]. The raw hit is used, so collisions are counted even while channel 0 is blinked off.
  - On frame_start: collide_mask <= acc, then acc is cleared.
  - If frame_start coincides with an accumulating pixel, that pixel's contribution goes into the cleared acc, not into collide_mask.
- **Flash counter (flash_cnt, 8 bits):**
  - hit_pulse loads FLASH_FRAMES, retriggering at any time.
  - Otherwise frame_start decrements flash_cnt when it is non-zero.
  - hit_pulse and frame_start in the same cycle: the load wins.
  - flashing is registered and equals (flash_cnt != 0).

## Timing
- Latency is exactly 2 clk from x/y/active/overlay/obj_* to VGA_*/pix_valid. Throughput is 1 pixel per clk.
- collide_mask updates 1 clk after frame_start and holds for the whole frame.
- flashing rises 1 clk after hit_pulse and falls 1 clk after the frame_start that takes flash_cnt to 0. That is FLASH_FRAMES frame_starts after the last hit_pulse.
- Reset, asynchronous and active-low:
  - VGA_R/G/B = 0, pix_valid = 0, collide_mask = 0, flashing = 0.
  - acc, flash_cnt and all pipeline registers are cleared.
  - Reset mid-frame discards the partial accumulation. The first frame_start after reset reports only the collisions seen since reset.
- obj_* may change at any clk. Each pixel uses the values sampled with its own x/y.

## Test plan
- **Priority:** ch1 at (100,100,30,30) red and ch2 at (110,110,30,30) green, both enabled; scan y=115. Pixels x=100..109 → red; x=110..129 → red (ch1 wins); x=130..139 → green. Floor at y=316 → 808080. Overlay at (105,115) → overlay_rgb. Every output appears 2 clk after its x/y.
- **Edges:** obj_w=0 gives no hit. obj_x=1000 with obj_w=40 draws x=1000..1023 with no wrap to x=0..15. obj_en=0 gives no hit.
- **Collision:** ch0 overlaps ch2 only during frame n. collide_mask reads 4'b0100 after frame n+1's frame_start and 4'b0000 after frame n+2's. With ch0 blinked off, the overlap is still reported.
- **Flash:** with FLASH_FRAMES=8 and BLINK_LOG2=2, pulse hit_pulse. Channel 0 pixels show the background while flash_cnt = 4..7 and ch0 colour while flash_cnt = 1..3. flashing drops after 8 frame_starts. A hit_pulse coincident with frame_start leaves flash_cnt = 8.
- **Reset:** assert rst low mid-frame with flashing high. All outputs read 0 immediately, with no clk edge needed. After release, pix_valid follows active with 2-clk latency.
